// File: rtl/lcd_rx_pkg.sv
// Shared opcodes, FSM encodings and window payload for the 8080-style display bus receiver.
package lcd_rx_pkg;

  localparam int unsigned ADDR_W = 16;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPIN   = 8'h10;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_PASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CASET_P  = 3'd1;
  localparam logic [2:0] ST_PASET_P  = 3'd2;
  localparam logic [2:0] ST_RAMWR_HI = 3'd3;
  localparam logic [2:0] ST_RAMWR_LO = 3'd4;

  typedef enum logic [2:0] {
    RX_IDLE     = ST_IDLE,
    RX_CASET_P  = ST_CASET_P,
    RX_PASET_P  = ST_PASET_P,
    RX_RAMWR_HI = ST_RAMWR_HI,
    RX_RAMWR_LO = ST_RAMWR_LO
  } rx_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
  } lcd_window_t;

  function automatic lcd_window_t full_window(input int unsigned lim);
    lcd_window_t w;
    w.start_addr = '0;
    w.end_addr   = ADDR_W'(lim - 1);
    return w;
  endfunction

  // End is clamped to the panel edge first, then start is pulled down to end.
  function automatic lcd_window_t clamp_window(input logic [ADDR_W-1:0] s,
                                               input logic [ADDR_W-1:0] e,
                                               input logic [ADDR_W-1:0] lim_m1);
    lcd_window_t w;
    w.end_addr   = (e > lim_m1) ? lim_m1 : e;
    w.start_addr = (s > w.end_addr) ? w.end_addr : s;
    return w;
  endfunction

endpackage

// File: rtl/lcd_bus_receiver_if.sv
// Display write bus (initiator -> receiver) plus the decoded pixel/command outputs.
interface lcd_bus_receiver_if #(parameter int unsigned COORD_W = 9);
  logic               wr;
  logic               dcx;
  logic [7:0]         D;
  logic               pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [15:0]        pix_rgb;
  logic               cmd_valid;
  logic [7:0]         cmd_code;
  logic               display_on;
  logic               sleep_out;
  logic               err_unknown;

  modport master (
    output wr, dcx, D,
    input  pix_valid, pix_x, pix_y, pix_rgb, cmd_valid, cmd_code,
           display_on, sleep_out, err_unknown
  );

  modport slave (
    input  wr, dcx, D,
    output pix_valid, pix_x, pix_y, pix_rgb, cmd_valid, cmd_code,
           display_on, sleep_out, err_unknown
  );
endinterface

// File: rtl/lcd_rx_addr_counter.sv
// Column/page write pointer; snapshots the window on load and wraps within it on each step.
module lcd_rx_addr_counter
  import lcd_rx_pkg::*;
#(
  parameter int unsigned WIDTH   = 240,
  parameter int unsigned HEIGHT  = 320,
  parameter int unsigned COORD_W = 9
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               load,
  input  logic               step,
  input  lcd_window_t        col_win,
  input  lcd_window_t        row_win,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row
);

  lcd_window_t        col_win_q, col_win_d;
  lcd_window_t        row_win_q, row_win_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;

  always_comb begin
    col_win_d = col_win_q;
    row_win_d = row_win_q;
    col_d     = col_q;
    row_d     = row_q;
    if (load) begin
      col_win_d = col_win;
      row_win_d = row_win;
      col_d     = COORD_W'(col_win.start_addr);
      row_d     = COORD_W'(row_win.start_addr);
    end else if (step) begin
      if (ADDR_W'(col_q) == col_win_q.end_addr) begin
        col_d = COORD_W'(col_win_q.start_addr);
        if (ADDR_W'(row_q) == row_win_q.end_addr) row_d = COORD_W'(row_win_q.start_addr);
        else                                       row_d = row_q + COORD_W'(1);
      end else begin
        col_d = col_q + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      col_win_q <= full_window(WIDTH);
      row_win_q <= full_window(HEIGHT);
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      col_win_q <= col_win_d;
      row_win_q <= row_win_d;
      col_q     <= col_d;
      row_q     <= row_d;
    end
  end

  assign col = col_q;
  assign row = row_q;

endmodule

// File: rtl/lcd_bus_receiver.sv
// Decodes the 8080 write-bus byte stream into windowed RGB565 pixel writes and state flags.
// Define LCD_RX_SYNC_EN to pass wr/dcx/D through a 2-flop synchronizer before capture.
module lcd_bus_receiver
  import lcd_rx_pkg::*;
#(
  parameter int unsigned WIDTH   = 240,
  parameter int unsigned HEIGHT  = 320,
  parameter int unsigned COORD_W = 9
) (
  input  logic               clk,
  input  logic               nrst,
  lcd_bus_receiver_if.slave  bus
);

  logic       wr_in, dcx_in;
  logic [7:0] d_in;

`ifdef LCD_RX_SYNC_EN
  logic [1:0] wr_sync_q, dcx_sync_q;
  logic [7:0] d_s1_q, d_s2_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_sync_q  <= 2'b11;
      dcx_sync_q <= 2'b00;
      d_s1_q     <= '0;
      d_s2_q     <= '0;
    end else begin
      wr_sync_q  <= {wr_sync_q[0], bus.wr};
      dcx_sync_q <= {dcx_sync_q[0], bus.dcx};
      d_s1_q     <= bus.D;
      d_s2_q     <= d_s1_q;
    end
  end

  assign wr_in  = wr_sync_q[1];
  assign dcx_in = dcx_sync_q[1];
  assign d_in   = d_s2_q;
`else
  assign wr_in  = bus.wr;
  assign dcx_in = bus.dcx;
  assign d_in   = bus.D;
`endif

  logic               wr_q;
  logic               capture_c;
  logic [2:0]         state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [15:0]        par_start_q, par_start_d;
  logic [7:0]         par_end_hi_q, par_end_hi_d;
  logic [7:0]         hi_q, hi_d;
  lcd_window_t        col_win_q, col_win_d, row_win_q, row_win_d, win_new_c;
  logic [ADDR_W-1:0]  lim_c;
  logic               load_c, step_c;
  logic [COORD_W-1:0] cnt_col, cnt_row;
  logic               pix_valid_q, pix_valid_d, cmd_valid_q, cmd_valid_d;
  logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0]        pix_rgb_q, pix_rgb_d;
  logic [7:0]         cmd_code_q, cmd_code_d;
  logic               display_on_q, display_on_d, sleep_out_q, sleep_out_d;
  logic               err_unknown_q, err_unknown_d;

  assign capture_c = ~wr_q & wr_in;

  lcd_rx_addr_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .COORD_W(COORD_W)) u_addr (
    .clk(clk), .nrst(nrst), .load(load_c), .step(step_c),
    .col_win(col_win_q), .row_win(row_win_q), .col(cnt_col), .row(cnt_row)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    par_start_d   = par_start_q;
    par_end_hi_d  = par_end_hi_q;
    hi_d          = hi_q;
    col_win_d     = col_win_q;
    row_win_d     = row_win_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_rgb_d     = pix_rgb_q;
    cmd_valid_d   = 1'b0;
    cmd_code_d    = cmd_code_q;
    display_on_d  = display_on_q;
    sleep_out_d   = sleep_out_q;
    err_unknown_d = err_unknown_q;
    load_c        = 1'b0;
    step_c        = 1'b0;
    lim_c         = (state_q == ST_CASET_P) ? ADDR_W'(WIDTH - 1) : ADDR_W'(HEIGHT - 1);
    win_new_c     = clamp_window(par_start_q, {par_end_hi_q, d_in}, lim_c);

    if (capture_c && !dcx_in) begin
      // Any command aborts parameter/pixel assembly, including a pending half pixel.
      cmd_valid_d = 1'b1;
      cmd_code_d  = d_in;
      state_d     = ST_IDLE;
      case (d_in)
        OP_CASET:   begin state_d = ST_CASET_P; idx_d = 2'd0; end
        OP_PASET:   begin state_d = ST_PASET_P; idx_d = 2'd0; end
        OP_RAMWR:   begin state_d = ST_RAMWR_HI; load_c = 1'b1; end
        OP_SWRESET: begin
          col_win_d     = full_window(WIDTH);
          row_win_d     = full_window(HEIGHT);
          display_on_d  = 1'b0;
          sleep_out_d   = 1'b0;
          err_unknown_d = 1'b0;
        end
        OP_NOP:     ;
        OP_SLPIN:   sleep_out_d  = 1'b0;
        OP_SLPOUT:  sleep_out_d  = 1'b1;
        OP_DISPOFF: display_on_d = 1'b0;
        OP_DISPON:  display_on_d = 1'b1;
        default:    err_unknown_d = 1'b1;
      endcase
    end else if (capture_c) begin
      case (state_q)
        ST_CASET_P, ST_PASET_P: begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0:    par_start_d[15:8] = d_in;
            2'd1:    par_start_d[7:0]  = d_in;
            2'd2:    par_end_hi_d      = d_in;
            default: begin
              if (state_q == ST_CASET_P) col_win_d = win_new_c;
              else                       row_win_d = win_new_c;
              state_d = ST_IDLE;
            end
          endcase
        end
        ST_RAMWR_HI: begin
          hi_d    = d_in;
          state_d = ST_RAMWR_LO;
        end
        ST_RAMWR_LO: begin
          pix_valid_d = 1'b1;
          pix_x_d     = cnt_col;
          pix_y_d     = cnt_row;
          pix_rgb_d   = {hi_q, d_in};
          step_c      = 1'b1;
          state_d     = ST_RAMWR_HI;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q          <= 1'b1;
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      par_start_q   <= '0;
      par_end_hi_q  <= '0;
      hi_q          <= '0;
      col_win_q     <= full_window(WIDTH);
      row_win_q     <= full_window(HEIGHT);
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= '0;
      display_on_q  <= 1'b0;
      sleep_out_q   <= 1'b0;
      err_unknown_q <= 1'b0;
    end else begin
      wr_q          <= wr_in;
      state_q       <= state_d;
      idx_q         <= idx_d;
      par_start_q   <= par_start_d;
      par_end_hi_q  <= par_end_hi_d;
      hi_q          <= hi_d;
      col_win_q     <= col_win_d;
      row_win_q     <= row_win_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      display_on_q  <= display_on_d;
      sleep_out_q   <= sleep_out_d;
      err_unknown_q <= err_unknown_d;
    end
  end

  assign bus.pix_valid   = pix_valid_q;
  assign bus.pix_x       = pix_x_q;
  assign bus.pix_y       = pix_y_q;
  assign bus.pix_rgb     = pix_rgb_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_code    = cmd_code_q;
  assign bus.display_on  = display_on_q;
  assign bus.sleep_out   = sleep_out_q;
  assign bus.err_unknown = err_unknown_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Scoreboard bench for lcd_bus_receiver: expected pixels are queued as bytes are driven.
module tb_lcd_bus_receiver;

  localparam int unsigned COORD_W = 9;

  typedef struct {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [15:0]        rgb;
  } pix_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  lcd_bus_receiver_if #(.COORD_W(COORD_W)) bus ();

  lcd_bus_receiver #(.WIDTH(240), .HEIGHT(320), .COORD_W(COORD_W)) dut (
    .clk(clk), .nrst(nrst), .bus(bus)
  );

  pix_t exp_q[$];
  int   tests_run = 0;
  int   fails     = 0;
  int   pix_cnt   = 0;
  int   cmd_cnt   = 0;

  // Scoreboard: every pixel pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (nrst) begin
      if (bus.cmd_valid) cmd_cnt++;
      if (bus.pix_valid) begin
        pix_t e;
        pix_cnt++;
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL pix_unexpected: got (%0d,%0d) rgb=%h, expected no pixel",
                   bus.pix_x, bus.pix_y, bus.pix_rgb);
        end else begin
          e = exp_q.pop_front();
          if (bus.pix_x !== e.x || bus.pix_y !== e.y || bus.pix_rgb !== e.rgb) begin
            fails++;
            $display("FAIL pix_data: got (%0d,%0d) rgb=%h, expected (%0d,%0d) rgb=%h",
                     bus.pix_x, bus.pix_y, bus.pix_rgb, e.x, e.y, e.rgb);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic c, input logic [7:0] b);
    @(negedge clk);
    bus.wr  = 1'b0;
    bus.dcx = c;
    bus.D   = b;
    @(negedge clk);
    bus.wr  = 1'b1;
  endtask

  task automatic pixel(input logic [15:0] rgb, input int x, input int y);
    pix_t e;
    e.x   = COORD_W'(x);
    e.y   = COORD_W'(y);
    e.rgb = rgb;
    exp_q.push_back(e);
    send(1'b1, rgb[15:8]);
    send(1'b1, rgb[7:0]);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_rgb, bus.cmd_valid, bus.cmd_code,
         bus.display_on, bus.sleep_out, bus.err_unknown} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got pix_valid=%b cmd_code=%h disp=%b sleep=%b err=%b, expected all 0",
               bus.pix_valid, bus.cmd_code, bus.display_on, bus.sleep_out, bus.err_unknown);
    end
    nrst = 1'b1;
    settle();
  endtask

  task automatic test_power_cmds();
    int c0 = cmd_cnt;
    send(1'b0, 8'h29);
    send(1'b0, 8'h11);
    settle();
    tests_run++;
    if (cmd_cnt - c0 !== 2) begin
      fails++; $display("FAIL t1_cmd_pulses: got %0d, expected 2", cmd_cnt - c0);
    end
    tests_run++;
    if (bus.display_on !== 1'b1 || bus.sleep_out !== 1'b1) begin
      fails++; $display("FAIL t1_flags: got disp=%b sleep=%b, expected 1 1", bus.display_on, bus.sleep_out);
    end
    tests_run++;
    if (bus.cmd_code !== 8'h11 || bus.cmd_valid !== 1'b0) begin
      fails++; $display("FAIL t1_cmd_code: got %h valid=%b, expected 11 valid=0", bus.cmd_code, bus.cmd_valid);
    end
  endtask

  task automatic test_window_stream();
    logic [15:0] colors [4];
    int p0;
    colors[0] = 16'hF800; colors[1] = 16'h07E0; colors[2] = 16'h001F; colors[3] = 16'hFFFF;
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h0A); send(1'b1, 8'h00); send(1'b1, 8'h0B);
    send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'h05); send(1'b1, 8'h00); send(1'b1, 8'h06);
    p0 = pix_cnt;
    send(1'b1, 8'h55);
    settle();
    tests_run++;
    if (pix_cnt !== p0 || bus.err_unknown !== 1'b0) begin
      fails++; $display("FAIL t2_extra_data: got pixels=%0d err=%b, expected 0 0", pix_cnt - p0, bus.err_unknown);
    end
    send(1'b0, 8'h2C);
    for (int i = 0; i < 8; i++) pixel(colors[i % 4], 10 + (i % 2), 5 + ((i / 2) % 2));
    settle();
    tests_run++;
    if (exp_q.size() != 0 || pix_cnt - p0 !== 8) begin
      fails++; $display("FAIL t2_pixel_count: got %0d pending=%0d, expected 8 pending=0", pix_cnt - p0, exp_q.size());
    end
  endtask

  task automatic test_clamp();
    int p0 = pix_cnt;
    send(1'b0, 8'h2A); send(1'b1, 8'h01); send(1'b1, 8'h00); send(1'b1, 8'h01); send(1'b1, 8'h40);
    send(1'b0, 8'h2C);
    pixel(16'hF0F0, 239, 5);
    pixel(16'h0F0F, 239, 6);
    settle();
    tests_run++;
    if (exp_q.size() != 0 || pix_cnt - p0 !== 2) begin
      fails++; $display("FAIL t3_clamp_count: got %0d pending=%0d, expected 2 pending=0", pix_cnt - p0, exp_q.size());
    end
  endtask

  task automatic test_odd_bytes();
    int p0 = pix_cnt;
    send(1'b0, 8'h2C);
    pixel(16'h1234, 239, 5);
    send(1'b1, 8'hAB);
    send(1'b0, 8'h00);
    settle();
    tests_run++;
    if (pix_cnt - p0 !== 1 || bus.err_unknown !== 1'b0 || bus.cmd_code !== 8'h00) begin
      fails++; $display("FAIL t4_half_pixel: got pixels=%0d err=%b code=%h, expected 1 0 00",
                        pix_cnt - p0, bus.err_unknown, bus.cmd_code);
    end
    send(1'b1, 8'hCD);
    send(1'b1, 8'hEF);
    settle();
    tests_run++;
    if (pix_cnt - p0 !== 1) begin
      fails++; $display("FAIL t4_idle_drop: got pixels=%0d, expected 1", pix_cnt - p0);
    end
  endtask

  task automatic test_unknown_swreset();
    int p0;
    send(1'b0, 8'hB1);
    settle();
    tests_run++;
    if (bus.err_unknown !== 1'b1) begin
      fails++; $display("FAIL t5_err_set: got %b, expected 1", bus.err_unknown);
    end
    send(1'b0, 8'h29);
    send(1'b0, 8'h00);
    settle();
    tests_run++;
    if (bus.err_unknown !== 1'b1 || bus.display_on !== 1'b1) begin
      fails++; $display("FAIL t5_err_sticky: got err=%b disp=%b, expected 1 1", bus.err_unknown, bus.display_on);
    end
    send(1'b0, 8'h01);
    settle();
    tests_run++;
    if (bus.err_unknown !== 1'b0 || bus.display_on !== 1'b0 || bus.sleep_out !== 1'b0) begin
      fails++; $display("FAIL t5_swreset_flags: got err=%b disp=%b sleep=%b, expected 0 0 0",
                        bus.err_unknown, bus.display_on, bus.sleep_out);
    end
    p0 = pix_cnt;
    send(1'b0, 8'h2C);
    pixel(16'hAAAA, 0, 0);
    pixel(16'h5555, 1, 0);
    settle();
    tests_run++;
    if (exp_q.size() != 0 || pix_cnt - p0 !== 2) begin
      fails++; $display("FAIL t5_full_window: got %0d pending=%0d, expected 2 pending=0", pix_cnt - p0, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_paset();
    int p0;
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h05); send(1'b1, 8'h00); send(1'b1, 8'h06);
    send(1'b0, 8'h29);
    send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'h07);
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    tests_run++;
    if ({bus.pix_valid, bus.cmd_valid, bus.cmd_code, bus.display_on, bus.err_unknown} !== '0) begin
      fails++; $display("FAIL t6_async_reset: got cmd_code=%h disp=%b, expected 00 0", bus.cmd_code, bus.display_on);
    end
    @(negedge clk);
    nrst = 1'b1;
    p0 = pix_cnt;
    settle();
    tests_run++;
    if (pix_cnt !== p0 || bus.cmd_valid !== 1'b0) begin
      fails++; $display("FAIL t6_reset_exit: got pixels=%0d cmd_valid=%b, expected 0 0", pix_cnt - p0, bus.cmd_valid);
    end
    send(1'b0, 8'h2C);
    pixel(16'h0123, 0, 0);
    pixel(16'h4567, 1, 0);
    settle();
    tests_run++;
    if (exp_q.size() != 0 || pix_cnt - p0 !== 2) begin
      fails++; $display("FAIL t6_window_reset: got %0d pending=%0d, expected 2 pending=0", pix_cnt - p0, exp_q.size());
    end
  endtask

  initial begin
    bus.wr  = 1'b1;
    bus.dcx = 1'b0;
    bus.D   = 8'h00;
    test_reset();
    test_power_cmds();
    test_window_stream();
    test_clamp();
    test_odd_bytes();
    test_unknown_swreset();
    test_reset_mid_paset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
